bidir_link_buffer: RTL and testbench

- Clocked, parametrised successor to the combinational bidirectional buffer.
- Joins two ports, side A and side B, over one shared half-duplex FIFO; only one direction is active at a time.
- Direction is either forced by an input select or chosen by built-in arbitration; every direction change drains the FIFO, then inserts a programmable dead-time (turnaround).
- Sits between two peer agents that share one physical lane.

---
 rtl/bidir_link_pkg.sv | 20 ++
 rtl/bidir_link_fifo.sv | 57 +++++
 rtl/bidir_link_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_bidir_link_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_link_pkg.sv
// Shared types and constants for the bidirectional link buffer.
// Holds the direction FSM encoding, mode selectors and stats helpers.
package bidir_link_pkg;

    typedef enum logic [1:0] {
        DIR_AB = 2'd0,
        TURN   = 2'd1,
        DIR_BA = 2'd2
    } dir_state_t;

    localparam int MODE_FORCED = 0;
    localparam int MODE_AUTO   = 1;
    localparam int STAT_W      = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bidir_link_fifo.sv
// Synchronous first-word-fall-through FIFO shared by both link directions.
// Ports: clk, rst_n, push_i/push_data_i, pop_i, head_o, full_o, empty_o, count_o.
module bidir_link_fifo
    import bidir_link_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/bidir_link_buffer.sv
// Half-duplex link buffer: one shared FIFO, direction FSM with drain + turnaround.
// Ports: dir_sel, side A/B in+out valid/ready/data, cur_dir, turn_active, fifo_count.
// Optional macro BIDIR_LINK_STATS_EN adds ab_count, ba_count, turn_count outputs.
module bidir_link_buffer
    import bidir_link_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int TURNAROUND = 2,
    parameter int MODE       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dir_sel,
    input  logic                   a_in_valid,
    output logic                   a_in_ready,
    input  logic [WIDTH-1:0]       a_in_data,
    output logic                   a_out_valid,
    input  logic                   a_out_ready,
    output logic [WIDTH-1:0]       a_out_data,
    input  logic                   b_in_valid,
    output logic                   b_in_ready,
    input  logic [WIDTH-1:0]       b_in_data,
    output logic                   b_out_valid,
    input  logic                   b_out_ready,
    output logic [WIDTH-1:0]       b_out_data,
    output logic                   cur_dir,
    output logic                   turn_active,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef BIDIR_LINK_STATS_EN
    ,
    output logic [STAT_W-1:0]      ab_count,
    output logic [STAT_W-1:0]      ba_count,
    output logic [STAT_W-1:0]      turn_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] TURN_INIT =
        (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    dir_state_t       state_q;
    logic             cur_dir_q;
    logic             turn_active_q;
    logic             live_q;
    logic             sw_q;
    logic [3:0]       turn_q;
    logic [AW:0]      beat_q;
    logic [WIDTH-1:0] a_last_q;
    logic [WIDTH-1:0] b_last_q;

    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] push_data;
    logic             push;
    logic             pop;
    logic             a_pop;
    logic             b_pop;
    logic             ab_act;
    logic             ba_act;
    logic             in_dir;
    logic             cur_valid;
    logic             opp_valid;
    logic             sw_set;
    logic             sw_pend;
    logic             in_rdy;
    logic             drained;
    logic             go_turn;
    logic             turn_step;
    logic             flip;
    dir_state_t       opp_state;

    assign ab_act = (state_q == DIR_AB);
    assign ba_act = (state_q == DIR_BA);
    assign in_dir = ab_act | ba_act;

    assign cur_valid = ba_act ? b_in_valid : a_in_valid;
    assign opp_valid = ba_act ? a_in_valid : b_in_valid;

    // Arbitration: yield when the peer waits and we are idle or spent a full burst.
    assign sw_set = opp_valid && (!cur_valid || (beat_q == CW'(DEPTH)));

    always_comb begin
        sw_pend = 1'b0;
        if (in_dir) begin
            if (MODE == MODE_AUTO) begin
                sw_pend = sw_q || sw_set;
            end else begin
                sw_pend = (dir_sel != cur_dir_q);
            end
        end
    end

    assign in_rdy     = live_q && in_dir && !full && !sw_pend;
    assign a_in_ready = in_rdy && ab_act;
    assign b_in_ready = in_rdy && ba_act;

    assign push      = (a_in_valid && a_in_ready) || (b_in_valid && b_in_ready);
    assign push_data = ba_act ? b_in_data : a_in_data;

    assign b_out_valid = ab_act && !empty;
    assign a_out_valid = ba_act && !empty;
    assign b_pop       = b_out_valid && b_out_ready;
    assign a_pop       = a_out_valid && a_out_ready;
    assign pop         = a_pop || b_pop;

    // Out data keeps showing the last delivered word once the FIFO runs dry.
    assign b_out_data = b_out_valid ? head : b_last_q;
    assign a_out_data = a_out_valid ? head : a_last_q;

    assign cur_dir     = cur_dir_q;
    assign turn_active = turn_active_q;

    assign opp_state = cur_dir_q ? DIR_AB : DIR_BA;
    assign drained   = in_dir && sw_pend && empty;
    assign go_turn   = drained && (TURNAROUND != 0);
    assign turn_step = (state_q == TURN) && (turn_q != '0);
    assign flip      = (drained && (TURNAROUND == 0))
                     || ((state_q == TURN) && (turn_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DIR_AB;
            cur_dir_q     <= 1'b0;
            turn_active_q <= 1'b0;
            turn_q        <= '0;
            live_q        <= 1'b0;
            sw_q          <= 1'b0;
            beat_q        <= '0;
            a_last_q      <= '0;
            b_last_q      <= '0;
        end else begin
            live_q <= 1'b1;
            if (a_pop) begin
                a_last_q <= head;
            end
            if (b_pop) begin
                b_last_q <= head;
            end
            if (push && (beat_q != CW'(DEPTH))) begin
                beat_q <= beat_q + 1'b1;
            end
            if ((MODE == MODE_AUTO) && in_dir && sw_set) begin
                sw_q <= 1'b1;
            end
            unique case (1'b1)
                flip: begin
                    state_q       <= opp_state;
                    cur_dir_q     <= !cur_dir_q;
                    turn_active_q <= 1'b0;
                    beat_q        <= '0;
                    sw_q          <= 1'b0;
                end
                turn_step: begin
                    turn_q <= turn_q - 1'b1;
                end
                go_turn: begin
                    state_q       <= TURN;
                    turn_q        <= TURN_INIT;
                    turn_active_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    bidir_link_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count)
    );

`ifdef BIDIR_LINK_STATS_EN
    logic [STAT_W-1:0] ab_q;
    logic [STAT_W-1:0] ba_q;
    logic [STAT_W-1:0] tc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q <= '0;
            ba_q <= '0;
            tc_q <= '0;
        end else begin
            if (b_pop) begin
                ab_q <= sat_inc(ab_q);
            end
            if (a_pop) begin
                ba_q <= sat_inc(ba_q);
            end
            if (flip) begin
                tc_q <= sat_inc(tc_q);
            end
        end
    end

    assign ab_count   = ab_q;
    assign ba_count   = ba_q;
    assign turn_count = tc_q;
`endif

endmodule

// File: tb/tb_bidir_link_buffer.sv
// Bench for bidir_link_buffer: MODE 0 and MODE 1 instances side by side.
// Queue scoreboard per instance plus directed and random traffic.
module tb_bidir_link_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dir_sel;
    logic [1:0] a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0] cur_dir, turn_active;
    logic [7:0] a_in_data [2];
    logic [7:0] a_out_data [2];
    logic [7:0] b_in_data [2];
    logic [7:0] b_out_data [2];
    logic [2:0] fifo_count [2];
`ifdef BIDIR_LINK_STATS_EN
    logic [15:0] ab_count [2];
    logic [15:0] ba_count [2];
    logic [15:0] turn_count [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bidir_link_buffer #(
            .WIDTH      (8),
            .DEPTH      (DEPTH),
            .TURNAROUND (2),
            .MODE       (g)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .dir_sel     (dir_sel[g]),
            .a_in_valid  (a_in_valid[g]),
            .a_in_ready  (a_in_ready[g]),
            .a_in_data   (a_in_data[g]),
            .a_out_valid (a_out_valid[g]),
            .a_out_ready (a_out_ready[g]),
            .a_out_data  (a_out_data[g]),
            .b_in_valid  (b_in_valid[g]),
            .b_in_ready  (b_in_ready[g]),
            .b_in_data   (b_in_data[g]),
            .b_out_valid (b_out_valid[g]),
            .b_out_ready (b_out_ready[g]),
            .b_out_data  (b_out_data[g]),
            .cur_dir     (cur_dir[g]),
            .turn_active (turn_active[g]),
            .fifo_count  (fifo_count[g])
`ifdef BIDIR_LINK_STATS_EN
            ,
            .ab_count    (ab_count[g]),
            .ba_count    (ba_count[g]),
            .turn_count  (turn_count[g])
`endif
        );
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Entry = {source side (0=A,1=B), data}.
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic       side_log [$];
    int         edge_log [$];
    logic [1:0] pa_g;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] qpop(input int k);
        if (qsize(k) == 0) return 9'h1ff;
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int k, input logic [8:0] e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic inv();
        for (int k = 0; k < 2; k++) begin
            if (cur_dir[k]) begin
                chk("idle_a_in_ready", a_in_ready[k], 0);
                chk("idle_b_out_valid", b_out_valid[k], 0);
                chk("a_out_valid", a_out_valid[k], qsize(k) != 0);
            end else begin
                chk("idle_b_in_ready", b_in_ready[k], 0);
                chk("idle_a_out_valid", a_out_valid[k], 0);
                chk("b_out_valid", b_out_valid[k], qsize(k) != 0);
            end
            if (qsize(k) == DEPTH)
                chk("full_ready", a_in_ready[k] | b_in_ready[k], 0);
        end
    endtask

    // Called right after a negedge with inputs already driven.
    task automatic tick();
        logic [1:0] pa, pb, ra, rb;
        logic [7:0] da [2];
        logic [7:0] db [2];
        logic [7:0] oa [2];
        logic [7:0] ob [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            pa[k] = a_in_valid[k] && a_in_ready[k];
            pb[k] = b_in_valid[k] && b_in_ready[k];
            ra[k] = a_out_valid[k] && a_out_ready[k];
            rb[k] = b_out_valid[k] && b_out_ready[k];
            da[k] = a_in_data[k];
            db[k] = b_in_data[k];
            oa[k] = a_out_data[k];
            ob[k] = b_out_data[k];
        end
        @(posedge clk);
        cyc++;
        pa_g = pa;
        for (int k = 0; k < 2; k++) begin
            if (rb[k]) chk("b_out_word", {1'b0, ob[k]}, qpop(k));
            if (ra[k]) chk("a_out_word", {1'b1, oa[k]}, qpop(k));
            if (pa[k]) qpush(k, {1'b0, da[k]});
            if (pb[k]) qpush(k, {1'b1, db[k]});
            if (k == 1 && (pa[1] || pb[1])) begin
                side_log.push_back(pb[1]);
                edge_log.push_back(cyc);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("fifo_count", 32'(fifo_count[k]), 32'(qsize(k)));
        inv();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_a_in_ready"}, a_in_ready[0], 0);
        chk({tag, "_b_in_ready"}, b_in_ready[0], 0);
        chk({tag, "_a_out_valid"}, a_out_valid[0], 0);
        chk({tag, "_b_out_valid"}, b_out_valid[0], 0);
        chk({tag, "_cur_dir"}, cur_dir[0], 0);
        chk({tag, "_count"}, 32'(fifo_count[0]), 0);
        chk({tag, "_turn"}, turn_active[0], 0);
    endtask

    initial begin
        int tcnt, idx, runs, run_len;
        logic s0;
        rst_n = 1'b0;
        dir_sel = '0;
        a_in_valid = '0; b_in_valid = '0;
        a_out_ready = '0; b_out_ready = '0;
        for (int k = 0; k < 2; k++) begin
            a_in_data[k] = '0;
            b_in_data[k] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state.
        chk_quiet("rst");
        chk("rst_a_out_data", a_out_data[0], 0);
        chk("rst_b_out_data", b_out_data[1], 0);
        chk("rst_ready_m1", a_in_ready[1] | b_in_ready[1], 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_a_ready", a_in_ready[0], 1);
        chk("post_rst_b_ready", b_in_ready[0], 0);

        // 1: A->B stream, one cycle latency.
        b_out_ready[0] = 1'b1;
        a_in_valid[0] = 1'b1;
        a_in_data[0] = 8'h11;
        tick();
        chk("t1_valid", b_out_valid[0], 1);
        chk("t1_d11", b_out_data[0], 8'h11);
        a_in_data[0] = 8'h22;
        tick();
        chk("t1_d22", b_out_data[0], 8'h22);
        a_in_data[0] = 8'h33;
        tick();
        chk("t1_d33", b_out_data[0], 8'h33);
        chk("t1_b_in_ready", b_in_ready[0], 0);
        a_in_valid[0] = 1'b0;
        tick();
        chk("t1_empty_valid", b_out_valid[0], 0);
        chk("t1_hold_data", b_out_data[0], 8'h33);

        // 2: fill to full, then drain; 5th word enters after first free slot.
        b_out_ready[0] = 1'b0;
        a_in_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data[0] = 8'h60 + 8'(i);
            tick();
        end
        a_in_data[0] = 8'h64;
        chk("t2_full_count", 32'(fifo_count[0]), 4);
        chk("t2_full_ready", a_in_ready[0], 0);
        b_out_ready[0] = 1'b1;
        idx = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pa_g[0] && idx < 0) begin
                idx = i;
                a_in_valid[0] = 1'b0;
            end
            if (!a_in_valid[0] && q0.size() == 0) break;
        end
        chk("t2_fifth_cycle", idx, 1);
        chk("t2_drained", 32'(fifo_count[0]), 0);

        // 3: switch to B->A with two words queued.
        b_out_ready[0] = 1'b0;
        a_in_valid[0] = 1'b1;
        a_in_data[0] = 8'h44;
        tick();
        a_in_data[0] = 8'h55;
        tick();
        a_in_data[0] = 8'h66;
        dir_sel[0] = 1'b1;
        #1;
        chk("t3_ready_drop", a_in_ready[0], 0);
        a_in_valid[0] = 1'b0;
        b_out_ready[0] = 1'b1;
        tcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (turn_active[0]) tcnt++;
            if (cur_dir[0]) break;
        end
        chk("t3_turn_cycles", tcnt, 2);
        chk("t3_cur_dir", cur_dir[0], 1);
        chk("t3_b_ready", b_in_ready[0], 1);
        b_in_valid[0] = 1'b1;
        b_in_data[0] = 8'hA5;
        a_out_ready[0] = 1'b1;
        tick();
        chk("t3_a_valid", a_out_valid[0], 1);
        chk("t3_a_data", a_out_data[0], 8'hA5);
        b_in_valid[0] = 1'b0;
        tick();

        // 5: reset with words queued, then reset mid-TURN.
        a_out_ready[0] = 1'b0;
        b_in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_data[0] = 8'hB1 + 8'(i);
            tick();
        end
        b_in_valid[0] = 1'b0;
        chk("t5_queued", 32'(fifo_count[0]), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("t5_rst1");
        q0.delete();
        q1.delete();
        dir_sel[0] = 1'b0;
        a_out_ready[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_a_ready", a_in_ready[0], 1);
        chk("t5_a_data", a_out_data[0], 0);
        dir_sel[0] = 1'b1;
        tick();
        chk("t5_in_turn", turn_active[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("t5_rst2");
        dir_sel[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_a_ready2", a_in_ready[0], 1);
        chk("t5_cur_dir2", cur_dir[0], 0);
        tick();
        chk("t5_no_stale_b", b_out_valid[0], 0);
        chk("t5_no_stale_a", a_out_valid[0], 0);

        // 6: 3 beats A->B, one switch, 2 beats B->A.
        b_out_ready[0] = 1'b1;
        a_in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data[0] = 8'hC0 + 8'(i);
            tick();
        end
        a_in_valid[0] = 1'b0;
        dir_sel[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cur_dir[0]) break;
        end
        chk("t6_dir", cur_dir[0], 1);
        b_in_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_in_data[0] = 8'hD0 + 8'(i);
            tick();
        end
        b_in_valid[0] = 1'b0;
        repeat (2) tick();
`ifdef BIDIR_LINK_STATS_EN
        chk("t6_ab_count", ab_count[0], 3);
        chk("t6_ba_count", ba_count[0], 2);
        chk("t6_turn_count", turn_count[0], 1);
`endif

        // 4: MODE 1 contention, alternating bursts of DEPTH beats.
        side_log.delete();
        edge_log.delete();
        a_in_valid[1] = 1'b1;
        b_in_valid[1] = 1'b1;
        a_out_ready[1] = 1'b1;
        b_out_ready[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a_in_data[1] = 8'($urandom);
            b_in_data[1] = 8'($urandom);
            tick();
        end
        a_in_valid[1] = 1'b0;
        b_in_valid[1] = 1'b0;
        repeat (4) tick();
        s0 = (side_log.size() > 0) ? side_log[0] : 1'b1;
        chk("t4_first_side", s0, 0);
        runs = 0;
        run_len = 1;
        for (int i = 1; i < side_log.size(); i++) begin
            if (side_log[i] != side_log[i-1]) begin
                chk("t4_burst_len", run_len, DEPTH);
                chk("t4_switch_gap", edge_log[i] - edge_log[i-1], 5);
                runs++;
                run_len = 1;
            end else begin
                chk("t4_beat_gap", edge_log[i] - edge_log[i-1], 1);
                run_len++;
            end
        end
        chk("t4_enough_bursts", runs >= 5, 1);

        // Random traffic on both instances against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) dir_sel[0] = ~dir_sel[0];
            for (int k = 0; k < 2; k++) begin
                a_in_valid[k] = 1'($urandom);
                b_in_valid[k] = 1'($urandom);
                a_in_data[k] = 8'($urandom);
                b_in_data[k] = 8'($urandom);
                a_out_ready[k] = 1'($urandom);
                b_out_ready[k] = 1'($urandom);
            end
            tick();
        end
        a_in_valid = '0;
        b_in_valid = '0;
        a_out_ready = '1;
        b_out_ready = '1;
        repeat (12) tick();
        chk("rand_drain0", 32'(fifo_count[0]), 0);
        chk("rand_drain1", 32'(fifo_count[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
